// File: rtl/im_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory.
// Fetch (m0) and loader (m1) are granted in IDLE and served one transfer at a time.
module im_arbiter #(
  parameter int unsigned data_size = 32,
  parameter int unsigned addr_size = 10,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_write,
  input  logic [addr_size-1:0] m0_addr,
  input  logic [data_size-1:0] m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_write,
  input  logic [addr_size-1:0] m1_addr,
  input  logic [data_size-1:0] m1_wdata,
  output logic                 m0_grant,
  output logic                 m1_grant,
  output logic                 m0_done,
  output logic                 m1_done,
  output logic [data_size-1:0] rdata,
  output logic [1:0]           resp,
  output logic                 mem_enable,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [addr_size-1:0] mem_addr,
  output logic [data_size-1:0] mem_in,
  input  logic [data_size-1:0] mem_out,
  input  logic [1:0]           mem_resp,
  input  logic                 mem_ready,
  input  logic                 mem_finish,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic               last_m1;
  logic               owner_m1;
  logic [CNT_W-1:0]   cnt;

  logic               sel_m1_c;
  logic               take_c;
  logic               expire_c;
  logic [1:0]         fin_resp_c;
  logic               sel_write_c;
  logic [addr_size-1:0] sel_addr_c;
  logic [data_size-1:0] sel_wdata_c;

  // Winner selection: a tie goes to whoever was not granted last.
  always_comb begin
    sel_m1_c    = m1_req & (~m0_req | ~last_m1);
    take_c      = (state == IDLE) & mem_ready & (m0_req | m1_req);
    expire_c    = (cnt == CNT_W'(TIMEOUT - 1));
    fin_resp_c  = mem_finish ? mem_resp : RESP_ERROR;
    sel_write_c = sel_m1_c ? m1_write : m0_write;
    sel_addr_c  = sel_m1_c ? m1_addr  : m0_addr;
    sel_wdata_c = sel_m1_c ? m1_wdata : m0_wdata;
  end

  // Grant is issued in the same cycle the request is seen.
  assign m0_grant = take_c & ~sel_m1_c;
  assign m1_grant = take_c &  sel_m1_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_m1    <= 1'b1;
      owner_m1   <= 1'b0;
      cnt        <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      rdata      <= '0;
      resp       <= '0;
      mem_enable <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_c) begin
            owner_m1   <= sel_m1_c;
            last_m1    <= sel_m1_c;
            cnt        <= '0;
            mem_enable <= 1'b1;
            mem_read   <= ~sel_write_c;
            mem_write  <= sel_write_c;
            mem_addr   <= sel_addr_c;
            mem_in     <= sel_wdata_c;
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // A finish arriving on the last allowed cycle beats the timeout.
          if (mem_finish || expire_c) begin
            rdata      <= mem_finish ? mem_out : '0;
            resp       <= fin_resp_c;
            m0_done    <= ~owner_m1;
            m1_done    <= owner_m1;
            if ((fin_resp_c == RESP_ERROR) && (err_count != 8'hFF))
              err_count <= err_count + 8'd1;
            mem_enable <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_in     <= '0;
            state      <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!mem_finish && mem_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Transaction-level random bench for im_arbiter with a behavioural memory responder.
module tb_im_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned TO = 15;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_grant, m1_grant, m0_done, m1_done;
  logic [DW-1:0] rdata;
  logic [1:0]    resp;
  logic          mem_enable, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in, mem_out;
  logic [1:0]    mem_resp;
  logic          mem_ready, mem_finish;
  logic          busy;
  logic [7:0]    err_count;

  im_arbiter #(.data_size(DW), .addr_size(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m0_done(m0_done), .m1_done(m1_done),
    .rdata(rdata), .resp(resp),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_resp(mem_resp),
    .mem_ready(mem_ready), .mem_finish(mem_finish),
    .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference state: arbitration history, last completion, error tally, pending requests.
  int            last_m1;
  int            err_m;
  logic [DW-1:0] rdata_m;
  logic [1:0]    resp_m;
  logic          pend [2];
  logic          pw   [2];
  logic [AW-1:0] pa   [2];
  logic [DW-1:0] pd   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_m1 = 1;
    err_m   = 0;
    rdata_m = '0;
    resp_m  = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d;
  endtask

  task automatic arrive();
    for (int i = 0; i < 2; i++)
      if (!pend[i] && ($urandom % 2 == 0))
        set_req(i, 1'($urandom), AW'($urandom), $urandom);
  endtask

  task automatic drive_masters();
    m0_req = pend[0]; m0_write = pw[0]; m0_addr = pa[0]; m0_wdata = pd[0];
    m1_req = pend[1]; m1_write = pw[1]; m1_addr = pa[1]; m1_wdata = pd[1];
  endtask

  task automatic check_hold(input string ph);
    check({ph, "_rdata"}, rdata, rdata_m);
    check({ph, "_resp"}, 32'(resp), 32'(resp_m));
    check({ph, "_err_count"}, 32'(err_count), 32'(err_m));
  endtask

  // Cycles with memory not ready: requests may pile up but nothing is granted.
  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      arrive();
      drive_masters();
      mem_ready = 1'b0; mem_finish = 1'b0; mem_out = $urandom; mem_resp = 2'($urandom);
      #1;
      check("idle_grant0", 32'(m0_grant), 32'(0));
      check("idle_grant1", 32'(m1_grant), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_mem_enable", 32'(mem_enable), 32'(0));
      check("idle_done", 32'({m0_done, m1_done}), 32'(0));
      check_hold("idle");
    end
  endtask

  // One arbitration + transfer. f: BUSY cycle (1-based) where memory finishes,
  // h: cycles finish stays high after done, rst_at: BUSY cycle to pulse reset (0 = none).
  task automatic txn(input int f, input logic [DW-1:0] mdata, input logic [1:0] mresp,
                     input int h, input int rst_at);
    int win, end_b, k;
    logic w; logic [AW-1:0] a; logic [DW-1:0] d;
    bit left;
    if (!pend[0] && !pend[1]) set_req(0, 1'($urandom), AW'($urandom), $urandom);
    @(negedge clk);
    drive_masters();
    mem_ready = 1'b1; mem_finish = 1'b0; mem_out = $urandom; mem_resp = 2'($urandom);
    #1;
    win = (pend[0] && pend[1]) ? ((last_m1 == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
    check("grant0", 32'(m0_grant), 32'(win == 0));
    check("grant1", 32'(m1_grant), 32'(win == 1));
    check("grant_busy", 32'(busy), 32'(0));
    last_m1 = win;
    w = pw[win]; a = pa[win]; d = pd[win];
    pend[win] = 1'b0;
    end_b = (f <= int'(TO)) ? f : int'(TO);

    for (int b = 1; b <= end_b; b++) begin
      @(negedge clk);
      drive_masters();
      mem_finish = (b == f);
      mem_out    = (b == f) ? mdata : $urandom;
      mem_resp   = (b == f) ? mresp : 2'($urandom);
      mem_ready  = 1'($urandom);
      #1;
      check("busy_enable", 32'(mem_enable), 32'(1));
      check("busy_read", 32'(mem_read), 32'(!w));
      check("busy_write", 32'(mem_write), 32'(w));
      check("busy_addr", 32'(mem_addr), 32'(a));
      check("busy_in", mem_in, d);
      check("busy_busy", 32'(busy), 32'(1));
      check("busy_grant", 32'({m0_grant, m1_grant}), 32'(0));
      check("busy_done", 32'({m0_done, m1_done}), 32'(0));
      if (b == rst_at) begin
        rst = 1'b1; mem_finish = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_masters();
        mem_ready = 1'b1; mem_finish = 1'b0;
        #1;
        check("rst_mem_enable", 32'(mem_enable), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'({m0_done, m1_done}), 32'(0));
        check_hold("rst");
        return;
      end
    end

    if (f <= int'(TO)) begin
      rdata_m = mdata; resp_m = mresp;
    end else begin
      rdata_m = '0; resp_m = 2'b01;
    end
    if (resp_m == 2'b01 && err_m < 255) err_m++;

    left = 1'b0;
    k = 0;
    while (!left && k < 40) begin
      @(negedge clk);
      arrive();
      drive_masters();
      mem_finish = (k < h);
      mem_ready  = (k >= h + 8) ? 1'b1 : (($urandom % 3) != 0);
      mem_out    = $urandom; mem_resp = 2'($urandom);
      #1;
      check("rel_done0", 32'(m0_done), 32'(k == 0 && win == 0));
      check("rel_done1", 32'(m1_done), 32'(k == 0 && win == 1));
      check("rel_grant", 32'({m0_grant, m1_grant}), 32'(0));
      check("rel_mem_enable", 32'(mem_enable), 32'(0));
      check("rel_busy", 32'(busy), 32'(1));
      check_hold("rel");
      left = !mem_finish && mem_ready;
      k++;
    end
    check("rel_exit", 32'(left), 32'(1));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    model_reset();
    rst = 1'b1;
    drive_masters();
    mem_ready = 1'b0; mem_finish = 1'b0; mem_out = '0; mem_resp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_mem_enable", 32'({mem_enable, mem_read, mem_write}), 32'(0));
    check("reset_mem_bus", 32'(mem_addr) | mem_in, 32'(0));
    check("reset_done", 32'({m0_done, m1_done}), 32'(0));
    check_hold("reset");

    // Tie from reset: m0, m1, m0 with requests held until granted.
    set_req(0, 1'b0, 10'h011, 32'h0);
    set_req(1, 1'b1, 10'h022, 32'hCAFE0001);
    txn(2, 32'hAAAA0000, 2'b00, 1, 0);
    set_req(0, 1'b1, 10'h033, 32'hBEEF0002);
    txn(1, 32'hBBBB0000, 2'b00, 0, 0);
    txn(3, 32'hCCCC0000, 2'b00, 0, 0);
    idle_cycles(1);

    // Single m0 read of 0x005, memory finishing one cycle after enable.
    set_req(0, 1'b0, 10'h005, 32'h0);
    txn(2, 32'h1234ABCD, 2'b00, 1, 0);
    idle_cycles(1);

    // m1 write with memory ERROR; RETRY/SPLIT passed through.
    set_req(1, 1'b1, 10'h3FF, 32'hFFFFFFFF);
    txn(1, 32'h0, 2'b01, 0, 0);
    set_req(1, 1'b0, 10'h100, 32'h0);
    txn(2, 32'h5555AAAA, 2'b10, 0, 0);
    set_req(0, 1'b0, 10'h101, 32'h0);
    txn(4, 32'h0F0F0F0F, 2'b11, 0, 0);

    // Timeout, finish exactly on the last cycle, one cycle too late, long finish hold.
    txn(99, 32'hDEAD0001, 2'b00, 0, 0);
    txn(15, 32'hDEAD0002, 2'b00, 1, 0);
    txn(16, 32'hDEAD0003, 2'b00, 2, 0);
    txn(2, 32'h77777777, 2'b00, 5, 0);

    // Reset mid-transfer, then a normal m1 transfer.
    set_req(0, 1'b0, 10'h044, 32'h0);
    txn(8, 32'h99999999, 2'b00, 0, 3);
    set_req(1, 1'b0, 10'h055, 32'h0);
    txn(2, 32'h13579BDF, 2'b00, 0, 0);

    for (int t = 0; t < 300; t++) begin
      int r, f;
      arrive();
      r = $urandom % 10;
      f = (r < 6) ? int'($urandom_range(1, 4)) :
          (r < 8) ? int'($urandom_range(5, 15)) : int'($urandom_range(14, 18));
      if ($urandom % 4 == 0) idle_cycles(int'($urandom_range(1, 2)));
      txn(f, $urandom, 2'($urandom), int'($urandom_range(0, 3)),
          ($urandom % 40 == 0) ? 1 : 0);
    end

    // Saturation of the error counter.
    for (int t = 0; t < 260; t++) begin
      set_req(1, 1'b1, AW'(t), $urandom);
      txn(1, 32'h0, 2'b01, 0, 0);
    end
    check("err_saturated", 32'(err_count), 32'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 Parameter data_size, 32, data word width.
REQ-002 Parameter addr_size, 10, word address width.
REQ-003 Parameter TIMEOUT, 15, maximum BUSY cycles allowed without mem_finish.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 m0_req / m1_req  in  1 each  access request; m0 is fetch, m1 is loader.
REQ-008 m0_write / m1_write  in  1 each  1 = write, 0 = read.
REQ-009 m0_addr / m1_addr  in  addr_size each  word address.
REQ-010 m0_wdata / m1_wdata  in  data_size each  write data.
REQ-011 m0_grant / m1_grant  out  1 each  one-cycle pulse; request captured.
REQ-012 m0_done / m1_done  out  1 each  one-cycle completion pulse.
REQ-013 rdata  out  data_size  read data, valid with a done pulse.
REQ-014 resp  out  2  completion response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11), valid with a done pulse.
REQ-015 mem_enable, mem_read, mem_write  out  1 each  memory controls.
REQ-016 mem_addr  out  addr_size; mem_in  out  data_size  memory address and write data.
REQ-017 mem_out  in  data_size; mem_resp  in  2; mem_ready, mem_finish  in  1 each  memory returns.
REQ-018 busy  out  1  state is not IDLE.
REQ-019 err_count  out  8  saturating count of ERROR completions.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY and RELEASE.
REQ-021 In IDLE with mem_ready=1 and any request pending: pick a winner, pulse its grant, latch its write/addr/wdata and owner id, then go to BUSY.
REQ-022 Arbitration SHALL be round-robin: with both requests pending, the requester not granted last wins; single requester always wins.
REQ-023 In BUSY: mem_enable=1; mem_read=!write and mem_write=write from the latched transfer; mem_addr/mem_in from latched values. Outside BUSY all mem_* outputs SHALL be 0.
REQ-024 On BUSY with mem_finish=1: capture mem_out into rdata and mem_resp into resp, pulse the owner's done next cycle, go to RELEASE.
REQ-025 The BUSY cycle counter SHALL reset on BUSY entry; if it reaches TIMEOUT without mem_finish: rdata=0, resp=ERROR, done pulse, go to RELEASE.
REQ-026 If mem_finish=1 on the timeout cycle, the finish SHALL win.
REQ-027 In RELEASE: wait until mem_finish=0 and mem_ready=1, then go to IDLE; no grant is issued in RELEASE.
REQ-028 Fixed timing (memory finishing 1 cycle after enable):
- req in cycle 0 -> grant in cycle 0
- mem_enable in cycles 1-2
- done in cycle 3
- IDLE again in cycle 5
REQ-029 Requests SHALL be sampled only in IDLE. A requester must drop req after its grant; req still high in IDLE is a new request.
REQ-030 rdata and resp SHALL hold their values until the next completion.
REQ-031 err_count SHALL increment on each completion with resp=ERROR (memory or timeout) and saturate at 255.
REQ-032 RETRY and SPLIT responses SHALL be passed through unchanged, with no automatic reissue.

Reset
REQ-033 When rst=1:
- state -> IDLE
- all grant/done/mem_* outputs, rdata, resp, err_count, busy and counter -> 0
- round-robin pointer set so m0 wins the first tie
REQ-034 rst asserted mid-transfer SHALL abandon it with no done pulse; mem_enable=0 in the cycle after reset.

Verification
REQ-035 m0 read of addr 0x005 with mem_out=0x1234ABCD, mem_finish 1 cycle after enable -> m0_grant cycle 0, m0_done cycle 3, rdata=0x1234ABCD, resp=00.
REQ-036 m0 and m1 request together, held until granted -> grants m0, then m1, then m0; each done goes only to its owner.
REQ-037 m1 write, memory returns ERROR -> m1_done, resp=01, err_count=1; 256 such writes -> err_count=255.
REQ-038 mem_finish held at 0 -> done after 15 BUSY cycles, resp=01, rdata=0; mem_finish on cycle 15 -> memory data returned.
REQ-039 rst pulsed in BUSY -> no done, mem_enable=0 next cycle, busy=0; a later m1 request completes normally.
REQ-040 mem_finish held at 1 after done -> state stays RELEASE and no grant until mem_finish=0.
